rv32_load_store_unit: RTL and testbench

//  Sits between the pipeline MEM stage and data port B of the main memory. Accepts
//  one load/store per valid/ready handshake and issues the memory_request_t. It waits
//  out the synchronous BRAM read latency, then byte/half-extracts and sign/zero-extends

---
 rtl/rv32_load_store_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_rv32_load_store_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_load_store_unit.sv
// RV32 load/store unit: sits between the MEM stage and memory data port B.
// Accepts one access per valid/ready handshake and drives the memory request.
// Loads wait out the BRAM read latency, then the unit extracts and extends the data.
// Misaligned or out-of-range accesses fault without touching memory.
// Op encoding (i_req_op / o_mem_request_op):
//   0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW.
module rv32_load_store_unit #(
  parameter int LOAD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic [3:0]  o_mem_request_op,
  output logic [31:0] o_mem_request_addr,
  output logic [31:0] o_mem_request_data,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_data,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_data,
  output logic        o_resp_fault
);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  // The counter is loaded with LOAD_LATENCY-1 and runs down to zero.
  localparam int CNT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RESP      = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_op;
  logic [1:0]       r_lane;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_resp_data;
  logic             r_resp_fault;

  logic w_accept;
  logic w_is_load;
  logic w_is_store;
  logic w_is_mem;
  logic w_misaligned;
  logic w_fault;

  // Picks the addressed byte or half out of the read word and extends it.
  function automatic logic [31:0] extract_load(input logic [3:0] op,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      MEM_LB:  res = {{24{b[7]}}, b};
      MEM_LBU: res = {24'd0, b};
      MEM_LH:  res = {{16{h[15]}}, h};
      MEM_LHU: res = {16'd0, h};
      MEM_LW:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Classifies the incoming op and checks its natural alignment.
  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    case (i_req_op)
      MEM_LB, MEM_LBU: w_is_load = 1'b1;
      MEM_LH, MEM_LHU: begin
        w_is_load    = 1'b1;
        w_misaligned = i_req_addr[0];
      end
      MEM_LW: begin
        w_is_load    = 1'b1;
        w_misaligned = |i_req_addr[1:0];
      end
      MEM_SB: w_is_store = 1'b1;
      MEM_SH: begin
        w_is_store   = 1'b1;
        w_misaligned = i_req_addr[0];
      end
      MEM_SW: begin
        w_is_store   = 1'b1;
        w_misaligned = |i_req_addr[1:0];
      end
      default: begin
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_misaligned = 1'b0;
      end
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;
  assign w_accept = i_req_valid & o_req_ready;
  // i_mem_ready is a function of the address we present, so the address must
  // not depend on the fault decision or a combinational loop would form.
  assign w_fault  = w_is_mem & (w_misaligned | ~i_mem_ready);
  assign o_mem_request_addr = w_accept ? i_req_addr : 32'd0;

  // Issues the op and store data only for an accepted, fault-free access.
  always_comb begin
    o_mem_request_op   = MEM_NOP;
    o_mem_request_data = 32'd0;
    if (w_accept && w_is_mem && !w_fault) begin
      o_mem_request_op   = i_req_op;
      o_mem_request_data = i_req_wdata;
    end else begin
      o_mem_request_op   = MEM_NOP;
      o_mem_request_data = 32'd0;
    end
  end

  // State register; reset drops any in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mem) begin
          if (w_fault || w_is_store) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_LOAD_WAIT;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD_WAIT: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_LOAD_WAIT;
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready and valid are mutually exclusive.
  always_comb begin
    o_req_ready  = (r_state == S_IDLE) & ~i_reset;
    o_resp_valid = (r_state == S_RESP);
  end

  // Latches the load context, runs the wait counter and holds the response payload.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op         <= MEM_NOP;
      r_lane       <= 2'd0;
      r_cnt        <= {CNT_W{1'b0}};
      r_resp_data  <= 32'd0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mem) begin
            r_op         <= i_req_op;
            r_lane       <= i_req_addr[1:0];
            r_cnt        <= CNT_INIT;
            r_resp_data  <= 32'd0;
            r_resp_fault <= w_fault;
          end
        end
        S_LOAD_WAIT: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            r_resp_data <= extract_load(r_op, r_lane, i_mem_data);
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_resp_data  = r_resp_data;
  assign o_resp_fault = r_resp_fault;

endmodule

// File: tb/tb_rv32_load_store_unit.sv
// Bench for rv32_load_store_unit: one instance with LOAD_LATENCY=1 and one with 3,
// each with its own byte-lane-steering memory model. Stimulus pushes expected
// responses into a scoreboard queue; a monitor pops on every response handshake.
module tb_rv32_load_store_unit;

  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        s_clk = 1'b0;
  logic        s_reset = 1'b1;
  logic        s_req_valid = 1'b0;
  int          s_sel = 0;
  logic [3:0]  s_req_op = NOP;
  logic [31:0] s_req_addr = 32'd0;
  logic [31:0] s_req_wdata = 32'd0;
  logic        s_resp_ready = 1'b1;

  logic        rr1, rv1, rf1, m1_ready;
  logic [31:0] rd1, m1_addr, m1_data, m1_rdata;
  logic [3:0]  m1_op;
  logic        rr3, rv3, rf3, m3_ready;
  logic [31:0] rd3, m3_addr, m3_data;
  logic [3:0]  m3_op;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] p3 [0:2];

  always #5 s_clk = ~s_clk;

  rv32_load_store_unit #(.LOAD_LATENCY(1)) dut1 (
    .i_clk(s_clk), .i_reset(s_reset),
    .i_req_valid(s_req_valid && s_sel == 0), .o_req_ready(rr1),
    .i_req_op(s_req_op), .i_req_addr(s_req_addr), .i_req_wdata(s_req_wdata),
    .o_mem_request_op(m1_op), .o_mem_request_addr(m1_addr), .o_mem_request_data(m1_data),
    .i_mem_ready(m1_ready), .i_mem_data(m1_rdata),
    .o_resp_valid(rv1), .i_resp_ready(s_resp_ready), .o_resp_data(rd1), .o_resp_fault(rf1)
  );

  rv32_load_store_unit #(.LOAD_LATENCY(3)) dut3 (
    .i_clk(s_clk), .i_reset(s_reset),
    .i_req_valid(s_req_valid && s_sel == 1), .o_req_ready(rr3),
    .i_req_op(s_req_op), .i_req_addr(s_req_addr), .i_req_wdata(s_req_wdata),
    .o_mem_request_op(m3_op), .o_mem_request_addr(m3_addr), .o_mem_request_data(m3_data),
    .i_mem_ready(m3_ready), .i_mem_data(p3[2]),
    .o_resp_valid(rv3), .i_resp_ready(s_resp_ready), .o_resp_data(rd3), .o_resp_fault(rf3)
  );

  // Views of whichever instance is selected.
  wire        s_rr   = (s_sel == 1) ? rr3 : rr1;
  wire        s_rv   = (s_sel == 1) ? rv3 : rv1;
  wire [31:0] s_rd   = (s_sel == 1) ? rd3 : rd1;
  wire [3:0]  s_mop  = (s_sel == 1) ? m3_op : m1_op;
  wire [31:0] s_madr = (s_sel == 1) ? m3_addr : m1_addr;
  wire [31:0] s_mdat = (s_sel == 1) ? m3_data : m1_data;

  // Memory is 4 KiB; anything above is out of range.
  assign m1_ready = (m1_addr < 32'h0000_1000);
  assign m3_ready = (m3_addr < 32'h0000_1000);

  function automatic logic [31:0] steer(input logic [31:0] old, input logic [3:0] op,
                                        input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] w;
    w = old;
    if (op == SB) w[8*lane +: 8] = wd[7:0];
    else if (op == SH) w[16*lane[1] +: 16] = wd[15:0];
    else if (op == SW) w = wd;
    return w;
  endfunction

  function automatic logic is_st(input logic [3:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
  end

  // Memory models: synchronous write with lane steering, registered read pipeline.
  always @(posedge s_clk) begin
    if (m1_ready && is_st(m1_op)) mem1[m1_addr[11:2]] <= steer(mem1[m1_addr[11:2]], m1_op, m1_addr[1:0], m1_data);
    m1_rdata <= mem1[m1_addr[11:2]];
    if (m3_ready && is_st(m3_op)) mem3[m3_addr[11:2]] <= steer(mem3[m3_addr[11:2]], m3_op, m3_addr[1:0], m3_data);
    p3[0] <= mem3[m3_addr[11:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per response handshake.
  always begin
    @(negedge s_clk);
    #2;
    if (!s_reset && s_resp_ready && (rv1 || rv3)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_resp actual=valid required=none at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_sel", rv3 ? 32'd1 : 32'd0, mon_e.sel);
        chk("sb_data", rv3 ? rd3 : rd1, mon_e.data);
        chk("sb_fault", {31'd0, rv3 ? rf3 : rf1}, {31'd0, mon_e.fault});
      end
    end
  end

  // One complete transaction with accept-cycle request checks and latency check.
  task automatic do_req(input string tag, input int sel, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_f, input int exp_lat);
    int w;
    int lat;
    @(negedge s_clk);
    s_sel = sel; s_req_op = op; s_req_addr = addr; s_req_wdata = wd;
    s_req_valid = 1'b1; s_resp_ready = 1'b1;
    #1;
    w = 0;
    while (!s_rr && w < 20) begin
      @(negedge s_clk);
      #1;
      w++;
    end
    chk({tag, "_req_ready"}, {31'd0, s_rr}, 32'd1);
    if (op == NOP || exp_f) begin
      chk({tag, "_mem_op_nop"}, {28'd0, s_mop}, {28'd0, NOP});
    end else begin
      chk({tag, "_mem_op"}, {28'd0, s_mop}, {28'd0, op});
      chk({tag, "_mem_addr"}, s_madr, addr);
      chk({tag, "_mem_data"}, s_mdat, wd);
    end
    if (op != NOP) sb_q.push_back('{sel, exp_d, exp_f});
    @(posedge s_clk);
    #1;
    s_req_valid = 1'b0;
    if (op == NOP) begin
      @(negedge s_clk);
      #1;
      chk({tag, "_no_resp"}, {31'd0, s_rv}, 32'd0);
    end else begin
      lat = 1;
      @(negedge s_clk);
      #1;
      while (!s_rv && lat < 20) begin
        @(negedge s_clk);
        #1;
        lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      @(posedge s_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset values while reset is held
    repeat (3) @(negedge s_clk);
    #1;
    chk("rst_req_ready", {31'd0, rr1}, 32'd0);
    chk("rst_resp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_resp_data", rd1, 32'd0);
    chk("rst_resp_fault", {31'd0, rf1}, 32'd0);
    chk("rst_mem_op", {28'd0, m1_op}, 32'd0);
    chk("rst_mem_addr", m1_addr, 32'd0);
    chk("rst_mem_data", m1_data, 32'd0);
    s_reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, rr1}, 32'd1);

    // Store then load
    do_req("t1_sw", 0, SW, 32'h100, 32'hDEADBEEF, 32'd0, 1'b0, 1);
    do_req("t1_lw", 0, LW, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 2);
    // Extraction on 0x80FF7F01
    do_req("t2_sw",  0, SW,  32'h200, 32'h80FF7F01, 32'd0, 1'b0, 1);
    do_req("t2_lb3", 0, LB,  32'h203, 32'd0, 32'hFFFFFF80, 1'b0, 2);
    do_req("t2_lbu3",0, LBU, 32'h203, 32'd0, 32'h00000080, 1'b0, 2);
    do_req("t2_lb0", 0, LB,  32'h200, 32'd0, 32'h00000001, 1'b0, 2);
    do_req("t2_lb2", 0, LB,  32'h202, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
    do_req("t2_lb1", 0, LB,  32'h201, 32'd0, 32'h0000007F, 1'b0, 2);
    do_req("t2_lh2", 0, LH,  32'h202, 32'd0, 32'hFFFF80FF, 1'b0, 2);
    do_req("t2_lhu0",0, LHU, 32'h200, 32'd0, 32'h00007F01, 1'b0, 2);
    do_req("t2_lhu2",0, LHU, 32'h202, 32'd0, 32'h000080FF, 1'b0, 2);
    do_req("t2_lh0", 0, LH,  32'h200, 32'd0, 32'h00007F01, 1'b0, 2);
    // Byte store with right-aligned data lands in lane 1
    do_req("t2_sb1", 0, SB,  32'h201, 32'h000000AA, 32'd0, 1'b0, 1);
    do_req("t2_lw",  0, LW,  32'h200, 32'd0, 32'h80FFAA01, 1'b0, 2);
    // Misaligned accesses fault and leave memory alone
    do_req("t3_sh",  0, SH,  32'h101, 32'h00001234, 32'd0, 1'b1, 1);
    do_req("t3_lw",  0, LW,  32'h102, 32'd0, 32'd0, 1'b1, 1);
    do_req("t3_sw",  0, SW,  32'h102, 32'h11111111, 32'd0, 1'b1, 1);
    do_req("t3_lhu", 0, LHU, 32'h201, 32'd0, 32'd0, 1'b1, 1);
    do_req("t3_chk", 0, LW,  32'h100, 32'd0, 32'hDEADBEEF, 1'b0, 2);
    // Out-of-range accesses fault
    do_req("t4_sw",  0, SW,  32'h00400000, 32'h55555555, 32'd0, 1'b1, 1);
    do_req("t4_lw",  0, LW,  32'h00400000, 32'd0, 32'd0, 1'b1, 1);
    do_req("t4_lbu", 0, LBU, 32'h00400000, 32'd0, 32'd0, 1'b1, 1);
    // NOP: accepted, no response
    do_req("nop",    0, NOP, 32'h100, 32'd0, 32'd0, 1'b0, 0);

    // Backpressure: response held for 5 cycles, next request queued behind it
    @(negedge s_clk);
    s_sel = 0; s_req_op = LW; s_req_addr = 32'h100; s_req_valid = 1'b1; s_resp_ready = 1'b0;
    #1;
    chk("t5_accept_ready", {31'd0, rr1}, 32'd1);
    sb_q.push_back('{0, 32'hDEADBEEF, 1'b0});
    @(posedge s_clk);
    #1;
    s_req_addr = 32'h200;
    w = 0;
    @(negedge s_clk);
    #1;
    while (!rv1 && w < 20) begin
      @(negedge s_clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid_held", {31'd0, rv1}, 32'd1);
      chk("t5_data_held", rd1, 32'hDEADBEEF);
      chk("t5_ready_low", {31'd0, rr1}, 32'd0);
      @(negedge s_clk);
      #1;
    end
    s_resp_ready = 1'b1;
    #1;
    chk("t5_hs_ready_low", {31'd0, rr1}, 32'd0);
    chk("t5_hs_no_issue", {28'd0, m1_op}, {28'd0, NOP});
    sb_q.push_back('{0, 32'h80FFAA01, 1'b0});
    @(negedge s_clk);
    #1;
    chk("t5_after_valid", {31'd0, rv1}, 32'd0);
    chk("t5_after_ready", {31'd0, rr1}, 32'd1);
    chk("t5_after_issue", {28'd0, m1_op}, {28'd0, LW});
    @(posedge s_clk);
    #1;
    s_req_valid = 1'b0;
    w = 0;
    @(negedge s_clk);
    #1;
    while (!rv1 && w < 20) begin
      @(negedge s_clk);
      #1;
      w++;
    end
    chk("t5_second_valid", {31'd0, rv1}, 32'd1);
    @(posedge s_clk);

    // Reset during LOAD_WAIT
    @(negedge s_clk);
    s_sel = 0; s_req_op = LW; s_req_addr = 32'h100; s_req_valid = 1'b1; s_resp_ready = 1'b1;
    @(posedge s_clk);
    #1;
    s_req_valid = 1'b0;
    @(negedge s_clk);
    s_reset = 1'b1;
    @(posedge s_clk);
    #1;
    chk("t6a_valid", {31'd0, rv1}, 32'd0);
    chk("t6a_mem_op", {28'd0, m1_op}, {28'd0, NOP});
    @(negedge s_clk);
    s_reset = 1'b0;
    #1;
    chk("t6a_ready", {31'd0, rr1}, 32'd1);
    @(negedge s_clk);
    #1;
    chk("t6a_no_late_resp", {31'd0, rv1}, 32'd0);

    // Reset during RESP
    s_req_op = SW; s_req_addr = 32'h300; s_req_wdata = 32'h0BADF00D;
    s_req_valid = 1'b1; s_resp_ready = 1'b0;
    @(posedge s_clk);
    #1;
    s_req_valid = 1'b0;
    @(negedge s_clk);
    #1;
    chk("t6b_in_resp", {31'd0, rv1}, 32'd1);
    s_reset = 1'b1;
    @(posedge s_clk);
    #1;
    chk("t6b_valid", {31'd0, rv1}, 32'd0);
    chk("t6b_mem_op", {28'd0, m1_op}, {28'd0, NOP});
    @(negedge s_clk);
    s_reset = 1'b0;
    s_resp_ready = 1'b1;
    #1;
    chk("t6b_ready", {31'd0, rr1}, 32'd1);

    // LOAD_LATENCY=3 instance
    do_req("t6_l3_sw", 1, SW, 32'h100, 32'h13579BDF, 32'd0, 1'b0, 1);
    do_req("t6_l3_lw", 1, LW, 32'h100, 32'd0, 32'h13579BDF, 1'b0, 4);
    do_req("t6_l3_lb", 1, LB, 32'h100, 32'd0, 32'hFFFFFFDF, 1'b0, 4);
    do_req("t6_l3_lh", 1, LH, 32'h102, 32'd0, 32'h00001357, 1'b0, 4);
    do_req("t6_l3_flt",1, LW, 32'h101, 32'd0, 32'd0, 1'b1, 1);

    repeat (3) @(negedge s_clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
